// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared forwarding encodings and MUL/DIV FSM states
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int RA_W_DEF = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // MEM wins over WB: it holds the younger value of the same register.
  function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem)     return FWD_MEM;
    else if (hit_wb) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_md_sequencer.sv
// ============================================================================
// md_sequencer : fixed-latency MUL/DIV occupancy FSM for the EX stage
// Revision     : 1.0
// ============================================================================
`default_nettype none

module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  output logic md_stall_o,
  output logic md_busy_o,
  output logic md_done_o
);

  md_state_e  state_q;
  logic [7:0] cnt_q;
  logic       busy_q;
  logic       done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_start_i) begin
            cnt_q  <= 8'(MD_LAT - 2);
            busy_q <= 1'b1;
            if (MD_LAT == 2) begin
              state_q <= MD_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (cnt_q == 8'd1) begin
            state_q <= MD_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        MD_DONE: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The last E cycle (DONE) lets the op advance, so it is not stalled.
  assign md_stall_o = md_start_i && (state_q != MD_DONE);
  assign md_busy_o  = busy_q;
  assign md_done_o  = done_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush/forwarding control for the 5-stage RISC-V pipe
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int RA_W   = RA_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  ra1D,
  input  logic [RA_W-1:0]  ra2D,
  input  logic [RA_W-1:0]  ra1E,
  input  logic [RA_W-1:0]  ra2E,
  input  logic [RA_W-1:0]  rdE,
  input  logic [RA_W-1:0]  rdM,
  input  logic [RA_W-1:0]  rdW,
  input  logic             reg_writeE,
  input  logic             reg_writeM,
  input  logic             reg_writeW,
  input  logic             mem_to_regE,
  input  logic             branch_takenE,
  input  logic             md_startE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic [1:0]       forward1E,
  output logic [1:0]       forward2E,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic md_stall;
  logic lu;
  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;
  logic branch_flush;
  logic unused_reg_write_e;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign unused_reg_write_e = reg_writeE;

  md_sequencer #(
    .MD_LAT (MD_LAT)
  ) u_md_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (md_startE),
    .md_stall_o (md_stall),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done)
  );

  assign forward1E = fwd_sel(reg_writeM && (rdM == ra1E) && (ra1E != '0),
                             reg_writeW && (rdW == ra1E) && (ra1E != '0));
  assign forward2E = fwd_sel(reg_writeM && (rdM == ra2E) && (ra2E != '0),
                             reg_writeW && (rdW == ra2E) && (ra2E != '0));

  assign lu = mem_to_regE && (rdE != '0) && ((rdE == ra1D) || (rdE == ra2D));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (md_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (branch_takenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Controls are held inactive for the whole time reset is asserted.
  assign stallF = rst_n & stall_f;
  assign stallD = rst_n & stall_d;
  assign stallE = rst_n & stall_e;
  assign flushD = rst_n & flush_d;
  assign flushE = rst_n & flush_e;
  assign flushM = rst_n & flush_m;

  assign branch_flush = rst_n && !md_stall && branch_takenE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : scoreboard bench for hazard_ctrl (MD_LAT=4, CNT_W=4)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int RA_W = 5;
  localparam int CW   = 4;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_MD   = 6'b111001;
  localparam logic [5:0] C_BR   = 6'b000110;

  typedef struct {
    logic [5:0]    ctl;
    logic [1:0]    f1;
    logic [1:0]    f2;
    logic          busy;
    logic          done;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [RA_W-1:0] ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW;
  logic reg_writeE, reg_writeM, reg_writeW, mem_to_regE, branch_takenE, md_startE;
  logic stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0] forward1E, forward2E;
  logic md_busy, md_done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  logic [CW-1:0] m_scnt = '0;
  logic [CW-1:0] m_fcnt = '0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MD_LAT (4),
    .RA_W   (RA_W),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ra1D          (ra1D),
    .ra2D          (ra2D),
    .ra1E          (ra1E),
    .ra2E          (ra2E),
    .rdE           (rdE),
    .rdM           (rdM),
    .rdW           (rdW),
    .reg_writeE    (reg_writeE),
    .reg_writeM    (reg_writeM),
    .reg_writeW    (reg_writeW),
    .mem_to_regE   (mem_to_regE),
    .branch_takenE (branch_takenE),
    .md_startE     (md_startE),
    .stallF        (stallF),
    .stallD        (stallD),
    .stallE        (stallE),
    .flushD        (flushD),
    .flushE        (flushE),
    .flushM        (flushM),
    .forward1E     (forward1E),
    .forward2E     (forward2E),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    {ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW} = '0;
    {reg_writeE, reg_writeM, reg_writeW, mem_to_regE, branch_takenE, md_startE} = '0;
  endtask

  // Push this cycle's expectation, then sample on the falling edge.
  task automatic expect_c(input logic [5:0] ctl, input logic [1:0] f1, input logic [1:0] f2,
                          input logic busy, input logic done);
    exp_t e;
    if (!rst_n) begin
      m_scnt = '0;
      m_fcnt = '0;
    end
    e.ctl = ctl; e.f1 = f1; e.f2 = f2; e.busy = busy; e.done = done;
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    if (rst_n && ctl[5] && (m_scnt != '1)) m_scnt = m_scnt + 1'b1;
    if (rst_n && ctl[2] && (m_fcnt != '1)) m_fcnt = m_fcnt + 1'b1;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ctl",       {26'd0, stallF, stallD, stallE, flushD, flushE, flushM}, {26'd0, e.ctl});
      chk("fwd1",      {30'd0, forward1E}, {30'd0, e.f1});
      chk("fwd2",      {30'd0, forward2E}, {30'd0, e.f2});
      chk("md_busy",   {31'd0, md_busy},   {31'd0, e.busy});
      chk("md_done",   {31'd0, md_done},   {31'd0, e.done});
      chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.scnt});
      chk("flush_cnt", {28'd0, flush_cnt}, {28'd0, e.fcnt});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    md_startE = 1'b1; mem_to_regE = 1'b1; rdE = 7; ra2D = 7; branch_takenE = 1'b1;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle();
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);

    // Forwarding priority
    ra1E = 5; ra2E = 5; rdM = 5; rdW = 5; reg_writeM = 1'b1; reg_writeW = 1'b1;
    expect_c(C_NONE, 2'b10, 2'b10, 1'b0, 1'b0);
    reg_writeM = 1'b0;
    expect_c(C_NONE, 2'b01, 2'b01, 1'b0, 1'b0);
    ra1E = 0;
    expect_c(C_NONE, 2'b00, 2'b01, 1'b0, 1'b0);
    ra2E = 3; rdM = 3; reg_writeM = 1'b1;
    expect_c(C_NONE, 2'b00, 2'b10, 1'b0, 1'b0);
    ra1E = 5; reg_writeM = 1'b0; reg_writeW = 1'b0;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();

    // Load-use
    mem_to_regE = 1'b1; rdE = 7; ra2D = 7;
    expect_c(C_LU, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    mem_to_regE = 1'b1; rdE = 0; ra1D = 0;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    mem_to_regE = 1'b0; rdE = 7; ra1D = 7;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();

    // MUL/DIV, with a load-use pattern present that must be ignored, then back-to-back
    md_startE = 1'b1; mem_to_regE = 1'b1; rdE = 7; ra1D = 7;
    expect_c(C_MD,   2'b00, 2'b00, 1'b0, 1'b0);
    expect_c(C_MD,   2'b00, 2'b00, 1'b1, 1'b0);
    expect_c(C_MD,   2'b00, 2'b00, 1'b1, 1'b0);
    mem_to_regE = 1'b0;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b1, 1'b1);
    expect_c(C_MD,   2'b00, 2'b00, 1'b0, 1'b0);
    expect_c(C_MD,   2'b00, 2'b00, 1'b1, 1'b0);
    expect_c(C_MD,   2'b00, 2'b00, 1'b1, 1'b0);
    expect_c(C_NONE, 2'b00, 2'b00, 1'b1, 1'b1);
    md_startE = 1'b0;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();

    // Branch with simultaneous load-use
    branch_takenE = 1'b1; mem_to_regE = 1'b1; rdE = 7; ra2D = 7;
    expect_c(C_BR, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset in the middle of an op, release with start still high
    md_startE = 1'b1;
    expect_c(C_MD, 2'b00, 2'b00, 1'b0, 1'b0);
    expect_c(C_MD, 2'b00, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b0;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    expect_c(C_MD,   2'b00, 2'b00, 1'b0, 1'b0);
    expect_c(C_MD,   2'b00, 2'b00, 1'b1, 1'b0);
    expect_c(C_MD,   2'b00, 2'b00, 1'b1, 1'b0);
    expect_c(C_NONE, 2'b00, 2'b00, 1'b1, 1'b1);
    md_startE = 1'b0;
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);

    // Stall counter saturation
    mem_to_regE = 1'b1; rdE = 7; ra2D = 7;
    repeat (20) expect_c(C_LU, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    expect_c(C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);

    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It generates stall and flush controls, the EX-stage operand forwarding selects, and sequences a fixed-latency multi-cycle MUL/DIV unit that occupies EX. It sits beside the datapath and drives its pipeline-register enables and clears. Saturating performance counters record stall and flush activity.

Parameters:
MD_LAT, 4, cycles a MUL/DIV op occupies EX (legal range 2..255)
RA_W, 5, register address width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
ra1D, ra2D  in  RA_W  source registers of the instruction in D
ra1E, ra2E  in  RA_W  source registers of the instruction in E
rdE, rdM, rdW  in  RA_W  destination registers in E/M/W
reg_writeE, reg_writeM, reg_writeW  in  1  stage writes the register file
mem_to_regE  in  1  instruction in E is a load
branch_takenE  in  1  redirect resolved in E
md_startE  in  1  instruction in E is MUL/DIV; level, held while it sits in E
stallF, stallD, stallE  out  1  hold the PC / IF-ID / ID-EX registers
flushD, flushE, flushM  out  1  clear the IF-ID / ID-EX / EX-MEM registers (bubble)
forward1E, forward2E  out  2  operand select: 00 none, 01 from WB, 10 from MEM
md_busy  out  1  MUL/DIV FSM not IDLE
md_done  out  1  MUL/DIV result valid this cycle (last cycle in E)
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, cnt=0, stall_cnt=flush_cnt=0. All stall, flush and md outputs are forced to 0 while rst_n=0. Forward outputs stay combinational.
- Forwarding (combinational, per operand n):
  - raE==rdM && reg_writeM && raE!=0 -> 10.
  - else raE==rdW && reg_writeW && raE!=0 -> 01.
  - else 00. MEM has priority when rdM==rdW.
- MD FSM states: IDLE, BUSY, DONE. 8-bit down-counter cnt.
  - IDLE, md_startE=1: cnt<=MD_LAT-2. Next state is DONE if MD_LAT==2, else BUSY.
  - BUSY: if cnt==1, next is DONE; else cnt<=cnt-1.
  - DONE: md_done=1, next is IDLE unconditionally. The same op does not restart.
  - A new md_startE in the IDLE cycle right after DONE starts a new op (back-to-back).
- md_stall = md_startE && state!=DONE. The op occupies E exactly MD_LAT cycles; stall covers the first MD_LAT-1 of them.
- md_busy = (state != IDLE).
- Load-use: lu = mem_to_regE && rdE!=0 && (rdE==ra1D || rdE==ra2D).
- Control priority (highest first):
  1. md_stall: stallF=stallD=stallE=1, flushM=1, flushD=flushE=0. Load-use and branch are ignored; branch_takenE cannot coincide with a MUL/DIV in E.
  2. branch_takenE: flushD=flushE=1, no stalls. A simultaneous lu is dropped because the D instruction is squashed.
  3. lu: stallF=stallD=1, flushE=1, for exactly one cycle. The next cycle the load is in M and forwarding covers the dependency.
  4. Otherwise all 0.
- Counters, updated on posedge:
  - stall_cnt += 1 when stallF=1.
  - flush_cnt += 1 when a branch flush is issued.
  - Both saturate at all-ones and never wrap.
- Reset mid-op: FSM returns to IDLE. After release, a still-high md_startE starts a fresh full MD_LAT sequence.

Decomposition:
- Shared package hazard_pkg: forward encodings FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; MD FSM state enum; RA_W default.
- One sub-module, md_sequencer: FSM, counter, md_busy, md_done, md_stall. Forwarding, priority logic and counters stay in the top.

Test Plan:
- Forward priority: ra1E=5, rdM=5, rdW=5, reg_writeM=reg_writeW=1 -> forward1E=10. Drop reg_writeM -> 01. Set ra1E=0 -> 00.
- Load-use: mem_to_regE=1, rdE=7, ra2D=7 for one cycle -> stallF=stallD=flushE=1 for exactly that cycle; stall_cnt increments by 1.
- MUL/DIV with MD_LAT=4: md_startE held 4 cycles -> stalls and flushM high in cycles 0-2; md_done=1 in cycle 3; md_busy high in cycles 1-3. Back-to-back op -> second sequence starts the cycle after DONE.
- Branch and load-use together: branch_takenE=1 with lu=1 -> flushD=flushE=1, stallF=0; flush_cnt increments by 1.
- Reset mid-op: drop rst_n in BUSY -> outputs go to 0 immediately, counters clear. Release with md_startE=1 -> full 4-cycle sequence.
- Saturation: with CNT_W=4, hold lu stall 20 cycles -> stall_cnt stays at 15.
